// File: rtl/flipper_pkg.sv
// Shared constants, speed/trig types and FSM states for the flipper bounce path.
package flipper_pkg;
    localparam int unsigned TRIG_ONE   = 1024;
    localparam int unsigned TRIG_SHIFT = 10;
    localparam int unsigned TRIG_W     = 12;
    localparam int unsigned SPEED_W    = 11;
    localparam int unsigned ALPHA_W    = 7;
    localparam int unsigned ALPHA_MAX  = 90;

    typedef logic signed [SPEED_W-1:0] speed_t;
    typedef logic signed [TRIG_W-1:0]  trig_t;

    typedef enum logic [2:0] {
        IDLE,
        ROTATE,
        REFLECT,
        UNROTATE,
        OUTPUT,
        COOLDOWN
    } state_t;
endpackage

// File: rtl/flipper_trig_rom.sv
// Combinational sine/cosine lookup, 0..90 degrees, scaled by TRIG_ONE.
module flipper_trig_rom
    import flipper_pkg::*;
(
    input  logic [ALPHA_W-1:0] i_alpha,
    output trig_t              o_cos,
    output trig_t              o_sin
);
    logic [ALPHA_W-1:0] w_alpha;

    // Only a sine table is stored; cos(a) is read as sin(90 - a).
    function automatic trig_t sin_lut(input logic [ALPHA_W-1:0] a);
        case (a)
            7'd0:  sin_lut = 12'sd0;    7'd1:  sin_lut = 12'sd18;   7'd2:  sin_lut = 12'sd36;
            7'd3:  sin_lut = 12'sd54;   7'd4:  sin_lut = 12'sd71;   7'd5:  sin_lut = 12'sd89;
            7'd6:  sin_lut = 12'sd107;  7'd7:  sin_lut = 12'sd125;  7'd8:  sin_lut = 12'sd143;
            7'd9:  sin_lut = 12'sd160;  7'd10: sin_lut = 12'sd178;  7'd11: sin_lut = 12'sd195;
            7'd12: sin_lut = 12'sd213;  7'd13: sin_lut = 12'sd230;  7'd14: sin_lut = 12'sd248;
            7'd15: sin_lut = 12'sd265;  7'd16: sin_lut = 12'sd282;  7'd17: sin_lut = 12'sd299;
            7'd18: sin_lut = 12'sd316;  7'd19: sin_lut = 12'sd333;  7'd20: sin_lut = 12'sd350;
            7'd21: sin_lut = 12'sd367;  7'd22: sin_lut = 12'sd384;  7'd23: sin_lut = 12'sd400;
            7'd24: sin_lut = 12'sd416;  7'd25: sin_lut = 12'sd433;  7'd26: sin_lut = 12'sd449;
            7'd27: sin_lut = 12'sd465;  7'd28: sin_lut = 12'sd481;  7'd29: sin_lut = 12'sd496;
            7'd30: sin_lut = 12'sd512;  7'd31: sin_lut = 12'sd527;  7'd32: sin_lut = 12'sd543;
            7'd33: sin_lut = 12'sd558;  7'd34: sin_lut = 12'sd573;  7'd35: sin_lut = 12'sd587;
            7'd36: sin_lut = 12'sd602;  7'd37: sin_lut = 12'sd616;  7'd38: sin_lut = 12'sd630;
            7'd39: sin_lut = 12'sd644;  7'd40: sin_lut = 12'sd658;  7'd41: sin_lut = 12'sd672;
            7'd42: sin_lut = 12'sd685;  7'd43: sin_lut = 12'sd698;  7'd44: sin_lut = 12'sd711;
            7'd45: sin_lut = 12'sd724;  7'd46: sin_lut = 12'sd737;  7'd47: sin_lut = 12'sd749;
            7'd48: sin_lut = 12'sd761;  7'd49: sin_lut = 12'sd773;  7'd50: sin_lut = 12'sd784;
            7'd51: sin_lut = 12'sd796;  7'd52: sin_lut = 12'sd807;  7'd53: sin_lut = 12'sd818;
            7'd54: sin_lut = 12'sd828;  7'd55: sin_lut = 12'sd839;  7'd56: sin_lut = 12'sd849;
            7'd57: sin_lut = 12'sd859;  7'd58: sin_lut = 12'sd868;  7'd59: sin_lut = 12'sd878;
            7'd60: sin_lut = 12'sd887;  7'd61: sin_lut = 12'sd896;  7'd62: sin_lut = 12'sd904;
            7'd63: sin_lut = 12'sd912;  7'd64: sin_lut = 12'sd920;  7'd65: sin_lut = 12'sd928;
            7'd66: sin_lut = 12'sd935;  7'd67: sin_lut = 12'sd943;  7'd68: sin_lut = 12'sd949;
            7'd69: sin_lut = 12'sd956;  7'd70: sin_lut = 12'sd962;  7'd71: sin_lut = 12'sd968;
            7'd72: sin_lut = 12'sd974;  7'd73: sin_lut = 12'sd979;  7'd74: sin_lut = 12'sd984;
            7'd75: sin_lut = 12'sd989;  7'd76: sin_lut = 12'sd994;  7'd77: sin_lut = 12'sd998;
            7'd78: sin_lut = 12'sd1002; 7'd79: sin_lut = 12'sd1005; 7'd80: sin_lut = 12'sd1008;
            7'd81: sin_lut = 12'sd1011; 7'd82: sin_lut = 12'sd1014; 7'd83: sin_lut = 12'sd1016;
            7'd84: sin_lut = 12'sd1018; 7'd85: sin_lut = 12'sd1020; 7'd86: sin_lut = 12'sd1022;
            7'd87: sin_lut = 12'sd1023; 7'd88: sin_lut = 12'sd1023; 7'd89: sin_lut = 12'sd1024;
            default: sin_lut = trig_t'(TRIG_ONE);
        endcase
    endfunction

    assign w_alpha = (i_alpha > ALPHA_W'(ALPHA_MAX)) ? ALPHA_W'(ALPHA_MAX) : i_alpha;
    assign o_sin   = sin_lut(w_alpha);
    assign o_cos   = sin_lut(ALPHA_W'(ALPHA_MAX) - w_alpha);
endmodule

// File: rtl/flipper_bounce.sv
// Reflects the ball speed off a flipper: rotate into the flipper frame, mirror
// the normal component (plus kick), rotate back, saturate, then wait out a cooldown.
module flipper_bounce
    import flipper_pkg::*;
#(
    parameter int          MAX_SPEED       = 400,
    parameter int          KICK            = 120,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collision,
    input  logic [ALPHA_W-1:0] alpha_in,
    input  logic               flipper_moving,
    input  speed_t             Xspeed_in,
    input  speed_t             Yspeed_in,
    output speed_t             Xspeed_out,
    output speed_t             Yspeed_out,
    output logic               bounce_valid,
    output logic               busy
);
    localparam int unsigned PROD_W = 24;
    localparam int unsigned TN_W   = 12;
    localparam int unsigned NP_W   = 13;
    localparam int unsigned SH_W   = 14;
    localparam int unsigned CNT_W  = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

    localparam logic signed [SH_W-1:0] MAX_POS = SH_W'(MAX_SPEED);
    localparam logic signed [SH_W-1:0] MAX_NEG = SH_W'(-MAX_SPEED);
    localparam logic signed [NP_W-1:0] KICK_S  = NP_W'(KICK);

    state_t                   r_state, w_next;
    logic [ALPHA_W-1:0]       r_alpha;
    speed_t                   r_vx, r_vy, r_xout, r_yout;
    logic                     r_moving, r_bv, r_busy;
    logic signed [TN_W-1:0]   r_t, r_n;
    logic signed [NP_W-1:0]   r_np;
    logic [CNT_W-1:0]         r_cool;
    trig_t                    w_cos, w_sin;
    logic signed [PROD_W-1:0] w_prod_t, w_prod_n, w_prod_x, w_prod_y;
    logic signed [SH_W-1:0]   w_x_sh, w_y_sh;
    logic                     w_capture, w_rotate, w_reflect, w_unrotate, w_cool_step;
    logic                     w_cool_last;

    function automatic speed_t sat(input logic signed [SH_W-1:0] v);
        if (v > MAX_POS)      sat = speed_t'(MAX_POS);
        else if (v < MAX_NEG) sat = speed_t'(MAX_NEG);
        else                  sat = speed_t'(v);
    endfunction

    flipper_trig_rom u_trig (
        .i_alpha (r_alpha),
        .o_cos   (w_cos),
        .o_sin   (w_sin)
    );

    assign w_prod_t = -(PROD_W'(r_vx) * PROD_W'(w_cos)) + PROD_W'(r_vy) * PROD_W'(w_sin);
    assign w_prod_n =   PROD_W'(r_vx) * PROD_W'(w_sin)  + PROD_W'(r_vy) * PROD_W'(w_cos);
    assign w_prod_x = -(PROD_W'(r_t)  * PROD_W'(w_cos)) + PROD_W'(r_np) * PROD_W'(w_sin);
    assign w_prod_y =   PROD_W'(r_t)  * PROD_W'(w_sin)  + PROD_W'(r_np) * PROD_W'(w_cos);
    assign w_x_sh   = SH_W'(w_prod_x >>> TRIG_SHIFT);
    assign w_y_sh   = SH_W'(w_prod_y >>> TRIG_SHIFT);

    assign w_cool_last = (r_cool == CNT_W'(COOLDOWN_FRAMES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (collision) w_next = ROTATE;
            ROTATE:   w_next = REFLECT;
            REFLECT:  w_next = (r_n > TN_W'(0)) ? UNROTATE : IDLE;
            UNROTATE: w_next = OUTPUT;
            OUTPUT:   w_next = COOLDOWN;
            COOLDOWN: if (startOfFrame && w_cool_last) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_capture   = 1'b0;
        w_rotate    = 1'b0;
        w_reflect   = 1'b0;
        w_unrotate  = 1'b0;
        w_cool_step = 1'b0;
        case (r_state)
            IDLE:     w_capture   = collision;
            ROTATE:   w_rotate    = 1'b1;
            REFLECT:  w_reflect   = 1'b1;
            UNROTATE: w_unrotate  = 1'b1;
            COOLDOWN: w_cool_step = startOfFrame;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alpha  <= '0;
            r_vx     <= '0;
            r_vy     <= '0;
            r_moving <= 1'b0;
            r_t      <= '0;
            r_n      <= '0;
            r_np     <= '0;
            r_xout   <= '0;
            r_yout   <= '0;
            r_cool   <= '0;
            r_bv     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_alpha  <= (alpha_in > ALPHA_W'(ALPHA_MAX)) ? ALPHA_W'(ALPHA_MAX) : alpha_in;
                r_vx     <= Xspeed_in;
                r_vy     <= Yspeed_in;
                r_moving <= flipper_moving;
            end
            if (w_rotate) begin
                r_t <= TN_W'(w_prod_t >>> TRIG_SHIFT);
                r_n <= TN_W'(w_prod_n >>> TRIG_SHIFT);
            end
            if (w_reflect) r_np <= -NP_W'(r_n) - (r_moving ? KICK_S : NP_W'(0));
            if (w_unrotate) begin
                r_xout <= sat(w_x_sh);
                r_yout <= sat(w_y_sh);
            end
            if (w_cool_step) r_cool <= w_cool_last ? '0 : r_cool + CNT_W'(1);
            r_bv   <= (w_next == OUTPUT);
            r_busy <= (w_next != IDLE);
        end
    end

    assign Xspeed_out   = r_xout;
    assign Yspeed_out   = r_yout;
    assign bounce_valid = r_bv;
    assign busy         = r_busy;
endmodule

// File: tb/tb_flipper_bounce.sv
// Directed bench for flipper_bounce: latency, reflection values, clamp, cooldown, reset.
module tb_flipper_bounce;
    import flipper_pkg::*;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               collision;
    logic [ALPHA_W-1:0] alpha_in;
    logic               flipper_moving;
    speed_t             Xspeed_in, Yspeed_in, Xspeed_out, Yspeed_out;
    logic               bounce_valid, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bv     = 0;
    int nb;

    flipper_bounce dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .collision      (collision),
        .alpha_in       (alpha_in),
        .flipper_moving (flipper_moving),
        .Xspeed_in      (Xspeed_in),
        .Yspeed_in      (Yspeed_in),
        .Xspeed_out     (Xspeed_out),
        .Yspeed_out     (Yspeed_out),
        .bounce_valid   (bounce_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bounce_valid) n_bv <= n_bv + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; collision is sampled at the next posedge (edge k).
    task automatic launch(input int a, input bit m, input int vx, input int vy);
        alpha_in       = 7'(a);
        flipper_moving = m;
        Xspeed_in      = speed_t'(vx);
        Yspeed_in      = speed_t'(vy);
        collision      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        collision      = 1'b0;
    endtask

    // Entered half a cycle after edge k; pulse must be seen only between k+3 and k+4.
    task automatic expect_bounce(input string tag, input int ex, input int ey);
        int nb0;
        nb0 = n_bv;
        check_val({tag, "_busy_k1"}, busy, 1);
        check_val({tag, "_bv_k1"}, bounce_valid, 0);
        repeat (2) @(negedge clk);
        check_val({tag, "_bv_k3"}, bounce_valid, 0);
        @(negedge clk);
        check_val({tag, "_bv_k4"}, bounce_valid, 1);
        check_val({tag, "_x"}, Xspeed_out, ex);
        check_val({tag, "_y"}, Yspeed_out, ey);
        @(negedge clk);
        check_val({tag, "_bv_after"}, bounce_valid, 0);
        check_val({tag, "_pulses"}, n_bv - nb0, 1);
    endtask

    task automatic finish_cooldown(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) startOfFrame = 1'b1;
            @(negedge clk) startOfFrame = 1'b0;
            if (i == 2) check_val({tag, "_busy_cool"}, busy, 1);
        end
        check_val({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic bounce(input string tag, input int a, input bit m, input int vx,
                          input int vy, input int ex, input int ey);
        @(negedge clk);
        launch(a, m, vx, vy);
        expect_bounce(tag, ex, ey);
        finish_cooldown(tag);
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
        alpha_in = '0; flipper_moving = 1'b0; Xspeed_in = '0; Yspeed_in = '0;
        #12;
        check_val("rst_x", Xspeed_out, 0);
        check_val("rst_y", Yspeed_out, 0);
        check_val("rst_bv", bounce_valid, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clk) resetN = 1'b1;

        bounce("a0_still",  0, 1'b0,   0, 200,    0, -200);
        bounce("a0_kick",   0, 1'b1,   0, 200,    0, -320);
        bounce("a0_clamp",  0, 1'b1,   0, 350,    0, -400);
        bounce("a90",      90, 1'b0, 150,   0, -150,    0);
        bounce("a45",      45, 1'b0,   0, 200, -200,    0);

        // Ball moving away from the surface: no pulse, back to IDLE after REFLECT.
        @(negedge clk);
        nb = n_bv;
        launch(0, 1'b0, 0, -100);
        check_val("away_bv_k1", bounce_valid, 0);
        @(negedge clk);
        check_val("away_busy_k2", busy, 1);
        @(negedge clk);
        check_val("away_busy_k3", busy, 0);
        check_val("away_hold_x", Xspeed_out, -200);
        check_val("away_hold_y", Yspeed_out, 0);
        check_val("away_pulses", n_bv - nb, 0);
        launch(0, 1'b0, 0, 200);
        expect_bounce("away_next", 0, -200);

        // Collisions during the first three cooldown frames are ignored.
        nb = n_bv;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) startOfFrame = 1'b1;
            @(negedge clk) startOfFrame = 1'b0;
            alpha_in = 7'd0; flipper_moving = 1'b1; Xspeed_in = '0;
            Yspeed_in = 11'sd200; collision = 1'b1;
            @(negedge clk) collision = 1'b0;
        end
        repeat (6) @(negedge clk);
        check_val("cool_pulses", n_bv - nb, 0);
        check_val("cool_hold_y", Yspeed_out, -200);
        check_val("cool_busy", busy, 1);
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
        check_val("cool_done", busy, 0);
        launch(0, 1'b0, 0, 250);
        expect_bounce("cool_next", 0, -250);
        finish_cooldown("cool_next");

        // Out-of-range angle clamps to 90; exercises the tangential path too.
        bounce("a100", 100, 1'b0, 100, 50, -100, 50);

        // Reset asserted while the bounce is in UNROTATE.
        @(negedge clk);
        nb = n_bv;
        launch(0, 1'b0, 0, 180);
        repeat (2) @(negedge clk);
        resetN = 1'b0;
        #1;
        check_val("mid_rst_x", Xspeed_out, 0);
        check_val("mid_rst_y", Yspeed_out, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_bv", bounce_valid, 0);
        @(negedge clk);
        @(negedge clk) resetN = 1'b1;
        repeat (4) @(negedge clk);
        check_val("mid_rst_pulses", n_bv - nb, 0);
        bounce("post_rst", 0, 1'b0, 0, 200, 0, -200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flipper_bounce.md
FLIPPER_BOUNCE -- requirements
Module: flipper_bounce

Interface
REQ-001 Parameters SHALL be: MAX_SPEED (400) speed clamp magnitude; KICK (120) extra normal speed when flipper moving; COOLDOWN_FRAMES (4) frames ignored after a bounce.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock
- resetN  in  1  reset
- startOfFrame  in  1  one-cycle frame pulse
- collision  in  1  ball pixel overlaps flipper pixel
- alpha_in  in  7  flipper angle, degrees 0..90
- flipper_moving  in  1  flipper swinging up
- Xspeed_in, Yspeed_in  in  11 signed each  current ball speed; screen Y grows down
- Xspeed_out, Yspeed_out  out  11 signed each  reflected speed
- bounce_valid  out  1  one-cycle pulse; outputs valid
- busy  out  1  high in any state except IDLE
REQ-003 One clock, clk; reset resetN is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, ROTATE, REFLECT, UNROTATE, OUTPUT, COOLDOWN.
REQ-005 IDLE, collision=1 at edge k: SHALL capture alpha_in (values >90 clamped to 90), both speeds and flipper_moving; go to ROTATE at k+1.
REQ-006 Collision SHALL be ignored in every state except IDLE.
REQ-007 c=cos(alpha), s=sin(alpha) SHALL come from a 91-entry table scaled by 1024 (cos 0=1024, sin 90=1024).
REQ-008 ROTATE SHALL register t=(-vx*c + vy*s)>>>10 and n=(vx*s + vy*c)>>>10; go to REFLECT.
REQ-009 REFLECT: n<=0 (ball leaving surface) -> IDLE, no pulse, outputs unchanged; otherwise register n' = -n, minus KICK if captured flipper_moving=1; go to UNROTATE.
REQ-010 UNROTATE SHALL register Xspeed_out=(-t*c + n'*s)>>>10 and Yspeed_out=(t*s + n'*c)>>>10, each saturated to [-MAX_SPEED, +MAX_SPEED]; go to OUTPUT.
REQ-011 OUTPUT SHALL assert bounce_valid for exactly one cycle (edge k+4); go to COOLDOWN.
REQ-012 COOLDOWN SHALL count startOfFrame pulses; on the COOLDOWN_FRAMES-th pulse go to IDLE. startOfFrame coinciding with collision in IDLE SHALL have no effect on cooldown.
REQ-013 Arithmetic: products in 24-bit signed; >>> is arithmetic (floor); n' in 13-bit signed before use.
REQ-014 Xspeed_out/Yspeed_out SHALL hold their last values between bounces.

Reset
REQ-015 resetN low SHALL force IDLE, cooldown counter 0, Xspeed_out=0, Yspeed_out=0, bounce_valid=0, busy=0, all captured registers 0, immediately and regardless of state; an in-flight bounce is discarded.

Structure
REQ-016 Package flipper_pkg SHALL hold TRIG_ONE=1024, the FSM state enum, and the signed 11-bit speed typedef.
REQ-017 Sine/cosine lookup SHALL be sub-module flipper_trig_rom (combinational, alpha in, c and s out), reusable by the flipper movers.

Verification
REQ-018 alpha=0, vx=0, vy=200, not moving, collision -> bounce_valid at k+4, out (0,-200), busy 1 from k+1 to end of cooldown.
REQ-019 Same, flipper_moving=1 -> out (0,-320); with vy=350 -> out (0,-400) (clamped).
REQ-020 alpha=90, vx=150, vy=0 -> out (-150,0).
REQ-021 alpha=0, vy=-100 -> no bounce_valid, returns to IDLE at k+3, outputs unchanged; new collision at k+3 accepted.
REQ-022 After a bounce, collisions during the next 3 frames ignored; collision after 4th startOfFrame produces a bounce.
REQ-023 resetN low during UNROTATE -> no pulse, outputs 0, state IDLE; next collision bounces normally.
